// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8 data bits LSB first, an even-parity bit and
// a stop bit, timed by a shared 16x baud-tick strobe. Each completed frame
// produces a one-cycle done pulse together with the byte and the error flags.
module uart_rx #(
    parameter int Data_bits = 9,
    parameter int St_ticks  = 8,
    parameter int Dt_ticks  = 16,
    parameter int Sp_ticks  = 16
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 s_ticks,
    input  logic                 rx,
    output logic [Data_bits-2:0] data_out,
    output logic                 rx_done_tick,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int DataW    = Data_bits - 1;
    localparam int MaxTicks = (Dt_ticks > Sp_ticks) ? Dt_ticks : Sp_ticks;
    localparam int CntW     = $clog2(MaxTicks);
    localparam int BitW     = $clog2(Data_bits);

    localparam logic [CntW-1:0] StLast   = CntW'(St_ticks - 1);
    localparam logic [CntW-1:0] DtLast   = CntW'(Dt_ticks - 1);
    localparam logic [CntW-1:0] SpLast   = CntW'(Sp_ticks - 1);
    localparam logic [BitW-1:0] DataLast = BitW'(DataW - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   tickCnt_q, tickCnt_d;
    logic [BitW-1:0]   bitCnt_q, bitCnt_d;
    logic [DataW-1:0]  shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              breakWait_q, breakWait_d;
    logic [DataW-1:0]  dataOut_q, dataOut_d;
    logic              parityErr_q, parityErr_d;
    logic              frameErr_q, frameErr_d;
    logic              doneTick_q, doneTick_d;
    logic              rxMeta_q;
    logic              rxSync_q;

    // Two-flop synchronizer for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            tickCnt_q   <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            breakWait_q <= 1'b0;
            dataOut_q   <= '0;
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            doneTick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tickCnt_q   <= tickCnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            breakWait_q <= breakWait_d;
            dataOut_q   <= dataOut_d;
            parityErr_q <= parityErr_d;
            frameErr_q  <= frameErr_d;
            doneTick_q  <= doneTick_d;
        end
    end

    // Next-state logic: frame sequencing, bit sampling and result capture.
    always_comb begin
        state_d     = state_q;
        tickCnt_d   = tickCnt_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        breakWait_d = breakWait_q;
        dataOut_d   = dataOut_q;
        parityErr_d = parityErr_q;
        frameErr_d  = frameErr_q;
        doneTick_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tickCnt_d = '0;
                // After a framing error the line must go high again before a
                // new start edge counts, so a held break cannot retrigger.
                if (breakWait_q) begin
                    if (rxSync_q) begin
                        breakWait_d = 1'b0;
                    end
                end else if (!rxSync_q) begin
                    state_d = START;
                end
            end

            START: begin
                if (s_ticks) begin
                    if (tickCnt_q == StLast) begin
                        tickCnt_d = '0;
                        if (!rxSync_q) begin
                            state_d  = DATA;
                            bitCnt_d = '0;
                            parity_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + CntW'(1);
                    end
                end
            end

            DATA: begin
                if (s_ticks) begin
                    if (tickCnt_q == DtLast) begin
                        tickCnt_d = '0;
                        shift_d   = {rxSync_q, shift_q[DataW-1:1]};
                        parity_d  = parity_q ^ rxSync_q;
                        if (bitCnt_q == DataLast) begin
                            state_d = PARITY;
                        end else begin
                            bitCnt_d = bitCnt_q + BitW'(1);
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + CntW'(1);
                    end
                end
            end

            PARITY: begin
                if (s_ticks) begin
                    if (tickCnt_q == DtLast) begin
                        tickCnt_d = '0;
                        parity_d  = parity_q ^ rxSync_q;
                        state_d   = STOP;
                    end else begin
                        tickCnt_d = tickCnt_q + CntW'(1);
                    end
                end
            end

            STOP: begin
                if (s_ticks) begin
                    if (tickCnt_q == SpLast) begin
                        tickCnt_d   = '0;
                        dataOut_d   = shift_q;
                        parityErr_d = parity_q;
                        frameErr_d  = ~rxSync_q;
                        breakWait_d = ~rxSync_q;
                        doneTick_d  = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        tickCnt_d = tickCnt_q + CntW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out     = dataOut_q;
    assign rx_done_tick = doneTick_q;
    assign parity_err   = parityErr_q;
    assign frame_err    = frameErr_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: drives whole frames bit by bit against a
// programmable tick strobe and checks the captured byte, flags and pulse count.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk;
    logic       Reset;
    logic       s_ticks;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;
    int tickDiv     = 4;
    int tickCnt     = 0;
    logic [9:0] doneLog[$];

    uart_rx dut (
        .clk          (clk),
        .Reset        (Reset),
        .s_ticks      (s_ticks),
        .rx           (rx),
        .data_out     (data_out),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick strobe: one clk wide, once every tickDiv clocks.
    initial begin
        s_ticks = 1'b0;
        forever begin
            @(negedge clk);
            if (tickCnt >= tickDiv - 1) begin
                s_ticks = 1'b1;
                tickCnt = 0;
            end else begin
                s_ticks = 1'b0;
                tickCnt++;
            end
        end
    end

    // Count done pulses and log {parity_err, frame_err, data_out} per frame.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_done_tick === 1'b1) begin
                doneCount++;
                doneLog.push_back({parity_err, frame_err, data_out});
            end
        end
    end

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic driveBit(input logic b);
        rx = b;
        waitClocks(16 * tickDiv);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic parityBit,
                                 input logic stopBit);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            driveBit(data[i]);
        end
        driveBit(parityBit);
        driveBit(stopBit);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Main directed sequence.
    initial begin
        int base;
        int baseIdx;

        Reset = 1'b1;
        rx    = 1'b1;
        waitClocks(3);
        checkOutput("reset data_out", 32'(data_out), 32'h0);
        checkOutput("reset done", 32'(rx_done_tick), 32'h0);
        checkOutput("reset parity_err", 32'(parity_err), 32'h0);
        checkOutput("reset frame_err", 32'(frame_err), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        Reset = 1'b0;
        waitClocks(20);

        $display("[TB] even-parity frame 0xA5");
        base = doneCount;
        applyStimulus(8'hA5, 1'b0, 1'b1);
        rx = 1'b1;
        waitClocks(20);
        checkOutput("A5 pulses", 32'(doneCount - base), 32'd1);
        checkOutput("A5 data", 32'(data_out), 32'hA5);
        checkOutput("A5 parity_err", 32'(parity_err), 32'h0);
        checkOutput("A5 frame_err", 32'(frame_err), 32'h0);
        checkOutput("A5 busy", 32'(busy), 32'h0);

        $display("[TB] parity error on 0x01");
        applyStimulus(8'h01, 1'b0, 1'b1);
        waitClocks(20);
        checkOutput("01 bad data", 32'(data_out), 32'h01);
        checkOutput("01 bad parity_err", 32'(parity_err), 32'h1);
        checkOutput("01 bad frame_err", 32'(frame_err), 32'h0);
        applyStimulus(8'h01, 1'b1, 1'b1);
        waitClocks(20);
        checkOutput("01 good parity_err", 32'(parity_err), 32'h0);

        $display("[TB] framing error and break on 0x3C");
        base = doneCount;
        applyStimulus(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        waitClocks(40 * tickDiv);
        checkOutput("break busy", 32'(busy), 32'h0);
        checkOutput("break pulses", 32'(doneCount - base), 32'd1);
        checkOutput("3C data", 32'(data_out), 32'h3C);
        checkOutput("3C frame_err", 32'(frame_err), 32'h1);
        checkOutput("3C parity_err", 32'(parity_err), 32'h0);
        rx = 1'b1;
        waitClocks(40);
        checkOutput("after break pulses", 32'(doneCount - base), 32'd1);

        $display("[TB] start glitch");
        base = doneCount;
        rx = 1'b0;
        waitClocks(4 * tickDiv);
        rx = 1'b1;
        waitClocks(100);
        checkOutput("glitch pulses", 32'(doneCount - base), 32'd0);
        checkOutput("glitch busy", 32'(busy), 32'h0);
        checkOutput("glitch data held", 32'(data_out), 32'h3C);
        checkOutput("glitch frame_err held", 32'(frame_err), 32'h1);
        applyStimulus(8'h5A, 1'b0, 1'b1);
        waitClocks(20);
        checkOutput("5A pulses", 32'(doneCount - base), 32'd1);
        checkOutput("5A data", 32'(data_out), 32'h5A);
        checkOutput("5A frame_err", 32'(frame_err), 32'h0);
        checkOutput("5A parity_err", 32'(parity_err), 32'h0);

        $display("[TB] reset during 0xFF, then 0x81");
        base = doneCount;
        driveBit(1'b0);
        for (int i = 0; i < 3; i++) begin
            driveBit(1'b1);
        end
        rx = 1'b1;
        waitClocks(8 * tickDiv);
        checkOutput("pre-reset busy", 32'(busy), 32'h1);
        Reset = 1'b1;
        waitClocks(2);
        checkOutput("mid reset data_out", 32'(data_out), 32'h0);
        checkOutput("mid reset done", 32'(rx_done_tick), 32'h0);
        checkOutput("mid reset flags", 32'({parity_err, frame_err}), 32'h0);
        checkOutput("mid reset busy", 32'(busy), 32'h0);
        waitClocks(4);
        Reset = 1'b0;
        waitClocks(16 * tickDiv * 8);
        checkOutput("aborted pulses", 32'(doneCount - base), 32'd0);
        applyStimulus(8'h81, 1'b0, 1'b1);
        waitClocks(20);
        checkOutput("81 pulses", 32'(doneCount - base), 32'd1);
        checkOutput("81 data", 32'(data_out), 32'h81);
        checkOutput("81 flags", 32'({parity_err, frame_err}), 32'h0);

        $display("[TB] back-to-back at one tick per clk");
        tickDiv = 1;
        waitClocks(10);
        base    = doneCount;
        baseIdx = doneLog.size();
        applyStimulus(8'h00, 1'b0, 1'b1);
        applyStimulus(8'hFF, 1'b0, 1'b1);
        applyStimulus(8'h55, 1'b0, 1'b1);
        rx = 1'b1;
        waitClocks(40);
        checkOutput("b2b pulses", 32'(doneCount - base), 32'd3);
        if (doneLog.size() >= baseIdx + 3) begin
            checkOutput("b2b frame0", 32'(doneLog[baseIdx]), 32'h000);
            checkOutput("b2b frame1", 32'(doneLog[baseIdx + 1]), 32'h0FF);
            checkOutput("b2b frame2", 32'(doneLog[baseIdx + 2]), 32'h055);
        end else begin
            checkOutput("b2b log size", 32'(doneLog.size() - baseIdx), 32'd3);
        end
        checkOutput("b2b busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
